spi_sclk_gen: RTL and testbench
===============================

# spi_sclk_gen

Programmable SPI serial-clock generator for the bridge's SPI master path. Produces SCLK with run-time half-period divisor, all four CPOL/CPHA modes, and a bounded burst of N bits per transfer. Emits per-edge sample/shift strobes for the shift-register datapath and a start/busy/done handshake toward the bridge controller. Supersedes the fixed-divisor free-running enable generator.

## Interface
- `DIV_W`, 16: width of the half-period divisor input.
- `BITS_W`, 6: width of the bit-count input; max burst 2^BITS_W − 1 bits.

- `clk`  in  1  system clock; all logic rising-edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `div`  in  DIV_W  SCLK half-period in `clk` cycles (H); 0 treated as 1.
- `cpol`  in  1  SCLK idle level.
- `cpha`  in  1  0: sample on leading edge; 1: shift on leading edge.
- `nbits`  in  BITS_W  bits per transfer; 0 treated as 1.
- `start`  in  1  one-cycle request; accepted only in IDLE.
- `abort`  in  1  terminate transfer immediately.
- `busy`  out  1  transfer in progress (SETUP/RUN/HOLD).
- `done`  out  1  one-cycle pulse on normal completion.
- `sclk`  out  1  serial clock.
- `sample_en`  out  1  one-cycle strobe: capture MISO now.
- `shift_en`  out  1  one-cycle strobe: advance MOSI now.

## Operation
- States: IDLE, SETUP, RUN, HOLD, DONE.
- IDLE: `sclk` registers `cpol` input (one-cycle follow). `start`=1 latches `div`, `cpol`, `cpha`, `nbits`; → SETUP, half-period counter cleared.
- Half-period counter: counts 0..H−1; "tick" when count == H−1, then wraps to 0. Counter width DIV_W, no overflow.
- SETUP: sclk held at latched cpol; on tick → RUN. Gives MOSI setup time before first edge.
- RUN: each tick toggles `sclk` and increments edge counter (BITS_W+1 bits). Odd edge = leading, even = trailing.
  - cpha=0: `sample_en` on leading, `shift_en` on trailing.
  - cpha=1: `shift_en` on leading, `sample_en` on trailing.
  - Strobes registered with `sclk`: high in the same cycle the new level appears.
  - After edge 2·nbits (sclk back at cpol) → HOLD.
- HOLD: one half-period, sclk at cpol; on tick → DONE.
- DONE: `done`=1, `busy`=0 for one cycle; → IDLE.
- `abort` (any non-IDLE state): next cycle IDLE, sclk=latched cpol, strobes 0, `done` not asserted. Abort beats tick in the same cycle.
- `start` while busy or in DONE: ignored. Input changes while busy: ignored (latched copies used).
- Simultaneous `start` and `abort` in IDLE: start wins.

## Timing
- Reset (rst_n=0 at edge): state IDLE, `sclk`=0, `busy`=0, `done`=0, `sample_en`=0, `shift_en`=0, counters 0. First IDLE cycle after reset: sclk takes `cpol`.
- Start accepted at edge k: `busy`=1 from cycle after k.
- First sclk toggle visible after edge k+2H.
- Last edge after edge k+(2·nbits+1)·H. `done` high for the cycle following edge k+(2·nbits+2)·H; `busy` low in that cycle.
- Total latency start→done: (2·nbits+2)·H+1 cycles. Back-to-back: next `start` accepted the cycle after `done`.
- Reset mid-transfer: identical to power-on reset; no `done`.

## Structure
- Shared package `spi_pkg`: state enum (IDLE/SETUP/RUN/HOLD/DONE), mode encoding constants (MODE0..MODE3 as {cpol,cpha}), default DIV_W/BITS_W.
- Sub-module `spi_half_period_cnt` (params DIV_W; ports clk, rst_n, clr, en, h, tick): the counter/tick logic, reusable by I2C SCL generation.
- Top holds FSM, edge counter, sclk/strobe registers.

## Test plan
- div=2, nbits=8, mode 0: start → first sclk rise at k+4, 8 `sample_en` on rises, 8 `shift_en` on falls, `done` at cycle k+37, busy high 36 cycles.
- Modes 1–3, div=1, nbits=4: sclk idles at cpol; strobes swap per cpha; exactly 8 edges, sclk ends at cpol.
- div=0 and nbits=0: behaves as H=1, one bit; `done` 5 cycles after start.
- abort in RUN after edge 3: next cycle IDLE, sclk=cpol, no `done`, no further strobes; subsequent start runs a full transfer.
- start pulsed while busy and div changed mid-transfer: no effect on period or length; rst_n=0 mid-RUN → all outputs 0, busy 0, no done.
- Back-to-back: start on the cycle after `done` → accepted, second transfer timing identical to first.

Source files
------------

// File: rtl/spi_sclk_gen_pkg.sv
// Shared definitions for the SPI serial-clock generator: FSM states, SPI mode
// encodings and default field widths.
package spi_pkg;

    localparam int DEF_DIV_W  = 16;
    localparam int DEF_BITS_W = 6;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RUN,
        HOLD,
        DONE
    } spi_state_t;

    // Modes are encoded as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_sclk_gen_if.sv
// Control/status bundle between the bridge controller (master) and the SCLK
// generator (slave).
interface spi_sclk_gen_if #(
    parameter int DIV_W  = spi_pkg::DEF_DIV_W,
    parameter int BITS_W = spi_pkg::DEF_BITS_W
);

    logic [DIV_W-1:0]  div;
    logic              cpol;
    logic              cpha;
    logic [BITS_W-1:0] nbits;
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              sclk;
    logic              sample_en;
    logic              shift_en;

    modport master (
        output div, cpol, cpha, nbits, start, abort,
        input  busy, done, sclk, sample_en, shift_en
    );

    modport slave (
        input  div, cpol, cpha, nbits, start, abort,
        output busy, done, sclk, sample_en, shift_en
    );

endinterface

// File: rtl/spi_half_period_cnt.sv
// Half-period counter: counts 0..h-1 while enabled and flags the wrap cycle.
// Kept generic so the I2C SCL generator can reuse it.
module spi_half_period_cnt #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] h,
    output logic             tick
);

    localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_cnt;
    logic             w_at_end;

    assign w_at_end = (r_cnt == (h - CNT_ONE));
    assign tick     = en && !clr && w_at_end;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_at_end ? '0 : (r_cnt + CNT_ONE);
        end
    end

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: programmable half-period, all four CPOL/CPHA
// modes, bounded bursts, per-edge sample/shift strobes and start/busy/done.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int DIV_W  = DEF_DIV_W,
    parameter int BITS_W = DEF_BITS_W
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_sclk_gen_if.slave bus
);

    localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
    localparam logic [BITS_W-1:0] BITS_ONE = BITS_W'(1);
    localparam logic [BITS_W:0]   EDGE_ONE = (BITS_W + 1)'(1);

    spi_state_t        r_state;
    spi_state_t        w_next_state;
    logic [DIV_W-1:0]  r_div;
    logic              r_cpol;
    logic              r_cpha;
    logic [BITS_W-1:0] r_nbits;
    logic [BITS_W:0]   r_edge;
    logic [BITS_W:0]   w_next_edge;
    logic [BITS_W:0]   w_edge_inc;
    logic [BITS_W:0]   w_last_edge;
    logic              r_sclk;
    logic              w_next_sclk;
    logic              r_sample;
    logic              w_next_sample;
    logic              r_shift;
    logic              w_next_shift;
    logic              w_accept;
    logic              w_active;
    logic              w_tick;
    logic              w_leading;

    assign w_accept    = (r_state == IDLE) && bus.start;
    assign w_active    = (r_state == SETUP) || (r_state == RUN) || (r_state == HOLD);
    assign w_edge_inc  = r_edge + EDGE_ONE;
    assign w_last_edge = {r_nbits, 1'b0};
    assign w_leading   = w_edge_inc[0];

    spi_half_period_cnt #(
        .DIV_W (DIV_W)
    ) u_half_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!w_active),
        .en    (w_active),
        .h     (r_div),
        .tick  (w_tick)
    );

    // Transfer parameters are frozen at start; zero divisor/length mean one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_nbits <= '0;
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
        end else if (w_accept) begin
            r_div   <= (bus.div == '0) ? DIV_ONE : bus.div;
            r_nbits <= (bus.nbits == '0) ? BITS_ONE : bus.nbits;
            r_cpol  <= bus.cpol;
            r_cpha  <= bus.cpha;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_edge   = r_edge;
        w_next_sclk   = r_sclk;
        w_next_sample = 1'b0;
        w_next_shift  = 1'b0;

        case (r_state)
            IDLE: begin
                w_next_sclk = bus.cpol;
                w_next_edge = '0;
                if (bus.start) begin
                    w_next_state = SETUP;
                end
            end
            SETUP: begin
                w_next_sclk = r_cpol;
                if (w_tick) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (w_tick) begin
                    w_next_sclk   = ~r_sclk;
                    w_next_edge   = w_edge_inc;
                    // Leading edges sample in cpha=0 and shift in cpha=1
                    w_next_sample = w_leading ^ r_cpha;
                    w_next_shift  = ~(w_leading ^ r_cpha);
                    if (w_edge_inc == w_last_edge) begin
                        w_next_state = HOLD;
                    end
                end
            end
            HOLD: begin
                w_next_sclk = r_cpol;
                if (w_tick) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_sclk  = r_cpol;
                w_next_edge  = '0;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
                w_next_edge  = '0;
            end
        endcase

        if (bus.abort && (r_state != IDLE)) begin
            w_next_state  = IDLE;
            w_next_edge   = '0;
            w_next_sclk   = r_cpol;
            w_next_sample = 1'b0;
            w_next_shift  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_edge   <= '0;
            r_sclk   <= 1'b0;
            r_sample <= 1'b0;
            r_shift  <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_edge   <= w_next_edge;
            r_sclk   <= w_next_sclk;
            r_sample <= w_next_sample;
            r_shift  <= w_next_shift;
        end
    end

    assign bus.busy      = w_active;
    assign bus.done      = (r_state == DONE);
    assign bus.sclk      = r_sclk;
    assign bus.sample_en = r_sample;
    assign bus.shift_en  = r_shift;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Bench for spi_sclk_gen: a cycle-accurate expected trace is queued per transfer
// and compared against {busy, done, sclk, sample_en, shift_en} every cycle.
module tb_spi_sclk_gen;
    import spi_pkg::*;

    localparam int DW = 16;
    localparam int BW = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int totalChecks = 0;
    int badChecks = 0;
    logic [4:0] expQ[$];

    spi_sclk_gen_if #(.DIV_W(DW), .BITS_W(BW)) bif ();

    spi_sclk_gen #(
        .DIV_W  (DW),
        .BITS_W (BW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [4:0] outVec();
        return {bif.busy, bif.done, bif.sclk, bif.sample_en, bif.shift_en};
    endfunction

    // Expected outputs t cycles after the start-accepting edge.
    function automatic logic [4:0] expVec(int t, int h, int n, logic cpol, logic cpha);
        int T;
        int e;
        int j;
        logic b, d, s, sa, sh, lead;
        T  = (2 * n + 2) * h;
        b  = (t < T);
        d  = (t == T);
        e  = (t < 2 * h) ? 0 : (t / h - 1);
        if (e > 2 * n) e = 2 * n;
        s  = cpol ^ ((e % 2) == 1);
        sa = 1'b0;
        sh = 1'b0;
        if ((t % h == 0) && (t >= 2 * h) && (t <= (2 * n + 1) * h)) begin
            j    = t / h - 1;
            lead = ((j % 2) == 1);
            sa   = lead ^ cpha;
            sh   = ~(lead ^ cpha);
        end
        return {b, d, s, sa, sh};
    endfunction

    task automatic checkOutput(input string tag, input logic [4:0] actual, input logic [4:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %b expected %b (busy,done,sclk,sample,shift)", tag, actual, expected);
        end
    endtask

    // One transfer; optional abort / reset at cycle abortAt / rstAt, optional
    // mid-transfer start pulse with altered inputs, optional abort alongside start.
    task automatic applyStimulus(input int divIn, input logic cpolIn, input logic cphaIn,
                                 input int nbitsIn, input int abortAt, input int rstAt,
                                 input bit perturb, input bit abortWithStart);
        int h;
        int n;
        int T;
        logic [4:0] quiet;
        h = (divIn == 0) ? 1 : divIn;
        n = (nbitsIn == 0) ? 1 : nbitsIn;
        T = (2 * n + 2) * h;

        @(posedge clk); #1;
        bif.div   = DW'(divIn);
        bif.cpol  = cpolIn;
        bif.cpha  = cphaIn;
        bif.nbits = BW'(nbitsIn);
        bif.start = 1'b1;
        bif.abort = abortWithStart;
        for (int t = 0; t <= T; t++) expQ.push_back(expVec(t, h, n, cpolIn, cphaIn));

        @(posedge clk); #1;
        bif.start = 1'b0;
        bif.abort = 1'b0;

        for (int t = 0; t <= T; t++) begin
            if (t > 0) begin
                @(posedge clk); #1;
            end
            checkOutput($sformatf("xfer d%0d n%0d t=%0d", divIn, nbitsIn, t), outVec(), expQ.pop_front());
            if (perturb && t == 3) begin
                bif.start = 1'b1;
                bif.div   = DW'(divIn + 3);
                bif.nbits = BW'(nbitsIn + 2);
                bif.cpha  = ~cphaIn;
            end
            if (perturb && t == 4) bif.start = 1'b0;
            if (t == abortAt || t == rstAt) begin
                if (t == abortAt) bif.abort = 1'b1;
                else rst_n = 1'b0;
                @(posedge clk); #1;
                bif.abort = 1'b0;
                rst_n = 1'b1;
                expQ.delete();
                quiet = {2'b00, cpolIn, 2'b00};
                if (t == abortAt) checkOutput("abort-next", outVec(), quiet);
                else checkOutput("reset-mid", outVec(), 5'b00000);
                for (int i = 0; i < 4; i++) begin
                    @(posedge clk); #1;
                    checkOutput($sformatf("quiet %0d", i), outVec(), quiet);
                end
                break;
            end
        end
    endtask

    initial begin
        logic [1:0] modes [3];
        modes = '{MODE1, MODE2, MODE3};

        bif.div   = '0;
        bif.cpol  = 1'b1;
        bif.cpha  = 1'b0;
        bif.nbits = '0;
        bif.start = 1'b0;
        bif.abort = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", outVec(), 5'b00000);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle-follow-1", outVec(), 5'b00100);
        bif.cpol = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle-follow-0", outVec(), 5'b00000);

        $display("[TB] mode 0, div=2, nbits=8");
        applyStimulus(2, MODE0[1], MODE0[0], 8, -1, -1, 1'b0, 1'b0);

        $display("[TB] modes 1-3, div=1, nbits=4");
        for (int m = 0; m < 3; m++) begin
            applyStimulus(1, modes[m][1], modes[m][0], 4, -1, -1, 1'b0, 1'b0);
        end

        $display("[TB] div=0 nbits=0 with abort alongside start");
        applyStimulus(0, 1'b0, 1'b0, 0, -1, -1, 1'b0, 1'b1);

        $display("[TB] abort after edge 3, then full transfer");
        applyStimulus(2, 1'b1, 1'b0, 4, 8, -1, 1'b0, 1'b0);
        applyStimulus(2, 1'b1, 1'b0, 4, -1, -1, 1'b0, 1'b0);

        $display("[TB] start and input changes while busy");
        applyStimulus(2, 1'b0, 1'b1, 8, -1, -1, 1'b1, 1'b0);

        $display("[TB] reset mid-RUN");
        applyStimulus(3, 1'b1, 1'b1, 5, -1, 12, 1'b0, 1'b0);

        $display("[TB] back-to-back transfers");
        applyStimulus(2, 1'b0, 1'b0, 8, -1, -1, 1'b0, 1'b0);
        applyStimulus(2, 1'b0, 1'b0, 8, -1, -1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
